// File: rtl/ic_skolem_pkg.sv
// Shared types and helpers for the bvsge/bvlshr Skolem search controller.
package ic_skolem_pkg;

    localparam int unsigned W   = 4;
    localparam int unsigned SKN = 8;

    typedef enum logic [1:0] {
        IDLE,
        HINT,
        SEARCH,
        RESP
    } state_t;

    // True when (x >>u s) >=s t; shift amounts of W or more clear the operand.
    function automatic logic ic_bvsge_lshr_holds(input logic [W-1:0] x,
                                                 input logic [W-1:0] s,
                                                 input logic [W-1:0] t);
        logic [W-1:0] sh;
        sh = (32'(s) >= W) ? '0 : (x >> s);
        return $signed(sh) >= $signed(t);
    endfunction

endpackage

// File: rtl/ic_rr_arb2.sv
// Two-way round-robin arbiter: pointer requester wins, pointer moves past the winner.
module ic_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = '0;
        if (en) begin
            if (req[ptr]) begin
                grant[ptr] = 1'b1;
            end else if (req[~ptr]) begin
                grant[~ptr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            ptr <= ~grant[1];
        end
    end

endmodule

// File: rtl/ic_skolem_search_ctrl.sv
// Arbitrates two (s, t) queries onto an external Skolem core, captures its hint,
// then serially searches for x with (x >>u s) >=s t and reports the outcome.
module ic_skolem_search_ctrl
    import ic_skolem_pkg::*;
#(
    parameter int unsigned W    = ic_skolem_pkg::W,
    parameter int unsigned MAXC = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    input  logic [2*W-1:0] req_s,
    input  logic [2*W-1:0] req_t,
    output logic [1:0]     req_ready,
    output logic [SKN-1:0] sk_in,
    input  logic           sk_out,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_x,
    output logic           rsp_found,
    output logic           rsp_mismatch,
    output logic           busy
);

    localparam int unsigned CW = (MAXC > 1) ? $clog2(MAXC) : 1;

    if (2 * W != SKN) begin : g_bad_width
        $error("ic_skolem_search_ctrl: 2*W must equal the core input count");
    end
    if (MAXC < 1 || MAXC > (1 << W)) begin : g_bad_maxc
        $error("ic_skolem_search_ctrl: MAXC out of range 1..2**W");
    end

    state_t          state;
    logic [W-1:0]    s_q, t_q, x_q;
    logic [CW-1:0]   cnt_q;
    logic            hint_q;
    logic            id_q;
    logic [1:0]      grant;
    logic            gnt_id;
    logic [W-1:0]    s_sel, t_sel;
    logic            pass;

    ic_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (state == IDLE),
        .grant (grant)
    );

    assign req_ready = grant;
    assign gnt_id    = grant[1];
    assign s_sel     = gnt_id ? req_s[2*W-1:W] : req_s[W-1:0];
    assign t_sel     = gnt_id ? req_t[2*W-1:W] : req_t[W-1:0];
    assign pass      = ic_bvsge_lshr_holds(x_q, s_q, t_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s_q          <= '0;
            t_q          <= '0;
            x_q          <= '0;
            cnt_q        <= '0;
            hint_q       <= 1'b0;
            id_q         <= 1'b0;
            sk_in        <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_x        <= '0;
            rsp_found    <= 1'b0;
            rsp_mismatch <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        s_q   <= s_sel;
                        t_q   <= t_sel;
                        id_q  <= gnt_id;
                        sk_in <= SKN'({t_sel, s_sel});
                        busy  <= 1'b1;
                        state <= HINT;
                    end
                end
                HINT: begin
                    // Start at the end of the range the hint points to.
                    hint_q <= sk_out;
                    x_q    <= sk_out ? '1 : '0;
                    cnt_q  <= '0;
                    state  <= SEARCH;
                end
                SEARCH: begin
                    if (pass) begin
                        rsp_x        <= x_q;
                        rsp_found    <= 1'b1;
                        rsp_mismatch <= ~hint_q;
                        rsp_id       <= id_q;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else if (cnt_q == CW'(MAXC - 1)) begin
                        rsp_x        <= '0;
                        rsp_found    <= 1'b0;
                        rsp_mismatch <= hint_q;
                        rsp_id       <= id_q;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else begin
                        x_q   <= x_q + 1'b1;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_skolem_search_ctrl.sv
// Directed and randomized checks of the Skolem search controller against an arithmetic model.
module tb_ic_skolem_search_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] req_s, req_t;
    logic [1:0] req_ready;
    logic [7:0] sk_in;
    logic       sk_out;
    logic       stub_hint;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_found, rsp_mismatch, busy;
    logic [3:0] rsp_x;

    int n_assert = 0;
    int n_fail   = 0;
    int ptr_m    = 0;

    assign sk_out = stub_hint;

    always #5 clk = ~clk;

    ic_skolem_search_ctrl #(.W(4), .MAXC(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_s        (req_s),
        .req_t        (req_t),
        .req_ready    (req_ready),
        .sk_in        (sk_in),
        .sk_out       (sk_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_x        (rsp_x),
        .rsp_found    (rsp_found),
        .rsp_mismatch (rsp_mismatch),
        .busy         (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int to_signed4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    function automatic bit model_pass(input int x, input int s, input int t);
        int sh;
        sh = (s >= 4) ? 0 : x / (1 << s);
        return to_signed4(sh) >= to_signed4(t);
    endfunction

    // Walk up to 16 candidates from the hinted start, wrapping modulo 16.
    task automatic ref_search(input int s, input int t, input bit hint,
                              output int found, output int x, output int tries);
        int c;
        c = hint ? 15 : 0;
        found = 0;
        x = 0;
        tries = 16;
        for (int i = 0; i < 16; i++) begin
            if (model_pass(c, s, t)) begin
                found = 1;
                x = c;
                tries = i + 1;
                break;
            end
            c = (c + 1) % 16;
        end
    endtask

    task automatic run_query(input logic [1:0] valids, input bit hold,
                             input int s0, input int t0, input int s1, input int t1,
                             input bit hint, input int stall);
        int id, s, t, found, x, tries, n, hint_i;
        id = valids[ptr_m] ? ptr_m : 1 - ptr_m;
        s  = (id == 1) ? s1 : s0;
        t  = (id == 1) ? t1 : t0;
        hint_i = hint ? 1 : 0;
        ref_search(s, t, hint, found, x, tries);
        stub_hint = hint;
        req_s     = {4'(s1), 4'(s0)};
        req_t     = {4'(t1), 4'(t0)};
        req_valid = valids;
        #1;
        check("grant", int'(req_ready), 1 << id);
        tick();
        ptr_m     = 1 - id;
        req_valid = hold ? valids : 2'b00;
        req_s     = 8'($urandom);
        req_t     = 8'($urandom);
        check("busy_set", int'(busy), 1);
        check("sk_in_hint", int'(sk_in), t * 16 + s);
        check("ready_low", int'(req_ready), 0);
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, 2 + tries);
        check("rsp_id", int'(rsp_id), id);
        check("rsp_x", int'(rsp_x), x);
        check("rsp_found", int'(rsp_found), found);
        check("rsp_mismatch", int'(rsp_mismatch), hint_i ^ found);
        check("sk_in_resp", int'(sk_in), t * 16 + s);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", int'(rsp_valid), 1);
            check("stall_id", int'(rsp_id), id);
            check("stall_x", int'(rsp_x), x);
            check("stall_found", int'(rsp_found), found);
            check("stall_ready", int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        #1;
        check("resp_no_grant", int'(req_ready), 0);
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_clr", int'(rsp_valid), 0);
        check("busy_clr", int'(busy), 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_s     = '0;
        req_t     = '0;
        rsp_ready = 1'b0;
        stub_hint = 1'b0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(rsp_valid), 0);
        check("rst_sk_in", int'(sk_in), 0);
        check("rst_x", int'(rsp_x), 0);
        check("rst_found", int'(rsp_found), 0);
        check("rst_mismatch", int'(rsp_mismatch), 0);
        check("rst_id", int'(rsp_id), 0);
        rst = 1'b0;
        tick();

        // Abandon a query during its third candidate.
        stub_hint = 1'b1;
        req_s     = 8'h03;
        req_t     = 8'h05;
        req_valid = 2'b01;
        #1;
        check("mid_grant", int'(req_ready), 1);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        check("mid_busy", int'(busy), 1);
        check("mid_valid", int'(rsp_valid), 0);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        ptr_m = 0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(rsp_valid), 0);
        check("mid_rst_sk_in", int'(sk_in), 0);

        run_query(2'b11, 1'b0, 0, 0, 9, 3, 1'b0, 0);
        run_query(2'b01, 1'b0, 1, 7, 0, 0, 1'b1, 0);
        run_query(2'b10, 1'b0, 0, 0, 0, 7, 1'b0, 0);
        run_query(2'b01, 1'b0, 3, 5, 0, 0, 1'b1, 0);
        run_query(2'b10, 1'b0, 0, 0, 2, 1, 1'b0, 1);

        // Both requesters held for four back-to-back queries, stall on the second.
        run_query(2'b11, 1'b1, 2, 3, 0, 4, 1'b0, 0);
        run_query(2'b11, 1'b1, 1, 2, 5, 0, 1'b1, 5);
        run_query(2'b11, 1'b1, 0, 8, 4, 9, 1'b1, 0);
        run_query(2'b11, 1'b0, 2, 6, 1, 15, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            run_query(2'($urandom_range(1, 3)), 1'b0,
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
